// File: rtl/frame_buffer_loader.sv
// Frame buffer loader: streams one frame from an AXI4-Stream slave into a
// beat-wide memory write port. Framing is checked against the configured
// resolution: short frames stop early, long frames are drained and discarded.
module frame_buffer_loader #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT = 1,
    parameter int NUMBER_OF_SUB_PIXELS      = 4,
    parameter int SUB_PIXEL_WIDTH           = 8,
    parameter int X_BIT_WIDTH               = 11,
    parameter int Y_BIT_WIDTH               = 11,
    parameter int FRAMEBUFFER_SIZE_IN_WORDS = 18,
    localparam int PW = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int SW = NUMBER_OF_PIXELS_PER_BEAT * PW,
    localparam int MW = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
    localparam int AW = FRAMEBUFFER_SIZE_IN_WORDS - $clog2(NUMBER_OF_PIXELS_PER_BEAT)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [X_BIT_WIDTH-1:0]          confXResolution,
    input  logic [Y_BIT_WIDTH-1:0]          confYResolution,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
    input  logic                            apply,
    input  logic                            cmdLoad,
    output logic                            applied,
    output logic                            error,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [SW-1:0]                   s_axis_tdata,
    output logic                            mem_wvalid,
    input  logic                            mem_wready,
    output logic [AW-1:0]                   mem_waddr,
    output logic [SW-1:0]                   mem_wdata,
    output logic [MW-1:0]                   mem_wstrb
);

    localparam int LOG2_PPB = $clog2(NUMBER_OF_PIXELS_PER_BEAT);
    // Wide enough for the full product and never narrower than AW.
    localparam int PRODW    = X_BIT_WIDTH + Y_BIT_WIDTH + AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic                      applied_q, applied_d;
    logic                      error_q, error_d;
    logic                      wvalid_q, wvalid_d;
    logic [AW-1:0]             count_q, count_d;
    logic [AW-1:0]             size_q, size_d;
    logic [NUMBER_OF_SUB_PIXELS-1:0] mask_q, mask_d;
    logic [AW-1:0]             waddr_q, waddr_d;
    logic [SW-1:0]             wdata_q, wdata_d;
    logic [MW-1:0]             wstrb_q, wstrb_d;

    logic [PRODW-1:0]          area;
    logic [AW-1:0]             size_calc;
    logic [MW-1:0]             strb_rep;
    logic                      tready;
    logic                      accept;
    logic                      last_beat;

    // Frame size in beats; truncation to AW bits is intentional.
    assign area      = PRODW'(confXResolution) * PRODW'(confYResolution);
    assign size_calc = AW'(area >> LOG2_PPB);

    // One copy of the latched sub-pixel mask per pixel in the beat.
    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_OF_PIXELS_PER_BEAT; gi++) begin : g_strb
            assign strb_rep[gi*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = mask_q;
        end
    endgenerate

    assign last_beat = (count_q == (size_q - AW'(1)));

    // Stream ready: backpressured by the single-entry write holding register.
    always_comb begin
        tready = 1'b0;
        case (state_q)
            LOAD:    tready = !wvalid_q || mem_wready;
            DRAIN:   tready = 1'b1;
            default: tready = 1'b0;
        endcase
        if (reset) begin
            tready = 1'b0;
        end
    end

    assign accept = s_axis_tvalid && tready;

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d   = state_q;
        applied_d = applied_q;
        error_d   = error_q;
        count_d   = count_q;
        size_d    = size_q;
        mask_d    = mask_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        // A pending write retires on mem_wready unless refilled below.
        wvalid_d  = wvalid_q && !mem_wready;

        case (state_q)
            IDLE: begin
                size_d  = size_calc;
                mask_d  = confMask;
                count_d = '0;
                if (apply && cmdLoad) begin
                    applied_d = 1'b0;
                    error_d   = 1'b0;
                    if (size_calc == '0) begin
                        // Nothing fits: swallow the frame and flag it.
                        error_d = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wvalid_d = 1'b1;
                    waddr_d  = count_q;
                    wdata_d  = s_axis_tdata;
                    wstrb_d  = strb_rep;
                    count_d  = count_q + AW'(1);
                    if (s_axis_tlast) begin
                        if (!last_beat) begin
                            error_d = 1'b1;
                        end
                        state_d = FLUSH;
                    end else if (last_beat) begin
                        error_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Complete in the same cycle the last write is acknowledged.
                if (!wvalid_q || mem_wready) begin
                    wvalid_d  = 1'b0;
                    applied_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            applied_q <= 1'b1;
            error_q   <= 1'b0;
            wvalid_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            applied_q <= applied_d;
            error_q   <= error_d;
            wvalid_q  <= wvalid_d;
            count_q   <= count_d;
        end
    end

    // Datapath registers; contents are don't-care while not valid.
    always_ff @(posedge clk) begin
        size_q  <= size_d;
        mask_q  <= mask_d;
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    assign s_axis_tready = tready;
    assign applied       = applied_q;
    assign error         = error_q;
    assign mem_wvalid    = wvalid_q;
    assign mem_waddr     = waddr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_frame_buffer_loader.sv
// Self-checking bench for frame_buffer_loader: a table of load scenarios run
// against 1- and 4-pixel-per-beat instances, with a write scoreboard, plus
// hand-written sequences for ignored commands and mid-load reset.
module tb_frame_buffer_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [10:0]   conf_x, conf_y;
    logic [3:0]    conf_mask;
    logic          apply, cmd_load;
    logic          tvalid, tlast;
    logic [127:0]  tdata;
    logic          mem_wready;

    logic          tready1, applied1, error1, wvalid1;
    logic [17:0]   waddr1;
    logic [31:0]   wdata1;
    logic [3:0]    wstrb1;
    logic          tready4, applied4, error4, wvalid4;
    logic [15:0]   waddr4;
    logic [127:0]  wdata4;
    logic [15:0]   wstrb4;

    frame_buffer_loader dut1 (
        .clk(clk), .reset(reset),
        .confXResolution(conf_x), .confYResolution(conf_y), .confMask(conf_mask),
        .apply(apply), .cmdLoad(cmd_load), .applied(applied1), .error(error1),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready1), .s_axis_tlast(tlast),
        .s_axis_tdata(tdata[31:0]),
        .mem_wvalid(wvalid1), .mem_wready(mem_wready), .mem_waddr(waddr1),
        .mem_wdata(wdata1), .mem_wstrb(wstrb1)
    );

    frame_buffer_loader #(.NUMBER_OF_PIXELS_PER_BEAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .confXResolution(conf_x), .confYResolution(conf_y), .confMask(conf_mask),
        .apply(apply), .cmdLoad(cmd_load), .applied(applied4), .error(error4),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready4), .s_axis_tlast(tlast),
        .s_axis_tdata(tdata),
        .mem_wvalid(wvalid4), .mem_wready(mem_wready), .mem_waddr(waddr4),
        .mem_wdata(wdata4), .mem_wstrb(wstrb4)
    );

    // Observed outputs of whichever instance the current scenario targets.
    logic          sel4;
    logic          tready_s, applied_s, error_s, wvalid_s;
    logic [17:0]   waddr_s;
    logic [127:0]  wdata_s;
    logic [15:0]   wstrb_s;
    assign tready_s  = sel4 ? tready4  : tready1;
    assign applied_s = sel4 ? applied4 : applied1;
    assign error_s   = sel4 ? error4   : error1;
    assign wvalid_s  = sel4 ? wvalid4  : wvalid1;
    assign waddr_s   = sel4 ? {2'b00, waddr4} : waddr1;
    assign wdata_s   = sel4 ? wdata4 : {96'd0, wdata1};
    assign wstrb_s   = sel4 ? wstrb4 : {12'd0, wstrb1};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [17:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int   cyc = 0;
    int   n_writes, first_wcyc, last_wcyc;
    logic load_phase = 1'b0;
    int   wr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory ready pattern: 0 = always, 1 = toggle, 2 = random.
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            0:       mem_wready = 1'b1;
            1:       mem_wready = ~mem_wready;
            default: mem_wready = 1'($urandom_range(0, 1));
        endcase
    end

    // Write monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wvalid_s && mem_wready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write to addr %0h, expected none", waddr_s);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("waddr", 128'(waddr_s), 128'(mon_e.addr));
                    check("wdata", wdata_s, mon_e.data);
                    check("wstrb", 128'(wstrb_s), 128'(mon_e.strb));
                    $display("write addr=%0h data=%0h strb=%0h", waddr_s, wdata_s, wstrb_s);
                end
                if (n_writes == 0) first_wcyc = cyc;
                last_wcyc = cyc;
                n_writes++;
            end
            if (load_phase && wvalid_s && !mem_wready) begin
                check("tready_while_stalled", 128'(tready_s), 128'(0));
            end
        end
    end

    typedef struct {
        bit         sel4;
        int         x, y;
        logic [3:0] mask;
        int         nbeats;
        bit         tlast_en;
        int         mode;
        int         exp_writes;
        bit         exp_err;
        bit         consec;
    } vec_t;
    vec_t vecs[10];

    // Drive beats 0..nbeats-1; pushes the expected write for each accepted beat.
    task automatic send_beats(input int row, input vec_t v, output bit ok);
        int  size;
        bit  acc;
        wr_t w;
        size = (v.x * v.y) / (v.sel4 ? 4 : 1);
        ok = 1'b1;
        load_phase = (size > 0);
        for (int i = 0; i < v.nbeats; i++) begin
            tvalid = 1'b1;
            tlast  = v.tlast_en && (i == v.nbeats - 1);
            if (row == 0) tdata = 128'(i);
            else          tdata = {$urandom, $urandom, $urandom, $urandom};
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                if (tready_s) begin
                    acc = 1'b1;
                    if (i < size) begin
                        w.addr = 18'(i);
                        w.data = v.sel4 ? tdata : {96'd0, tdata[31:0]};
                        w.strb = v.sel4 ? {4{v.mask}} : {12'd0, v.mask};
                        exp_q.push_back(w);
                    end
                end
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_accept_timeout: got no tready for beat %0d, expected acceptance", i);
                ok = 1'b0;
                break;
            end
            if (i + 1 >= size) load_phase = 1'b0;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        load_phase = 1'b0;
    endtask

    task automatic run_row(input int row, input vec_t v);
        bit ok;
        bit done;
        int done_cyc;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sel4 = v.sel4;
        wr_mode = v.mode;
        conf_x = 11'(v.x);
        conf_y = 11'(v.y);
        conf_mask = v.mask;
        exp_q.delete();
        n_writes = 0;
        @(posedge clk);
        #1;
        apply = 1'b1;
        cmd_load = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
        cmd_load = 1'b0;
        send_beats(row, v, ok);
        done = 1'b0;
        done_cyc = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (applied_s) begin
                done = 1'b1;
                done_cyc = cyc;
            end else begin
                check("tready_after_last", 128'(tready_s), 128'(0));
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL applied_timeout: got applied=0 in row %0d, expected 1", row);
        end
        check("write_count", 128'(n_writes), 128'(v.exp_writes));
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        check("error", 128'(error_s), 128'(v.exp_err));
        check("applied", 128'(applied_s), 128'(1));
        if (v.exp_writes > 0 && v.nbeats == v.exp_writes && done)
            check("ack_to_applied", 128'(done_cyc - last_wcyc), 128'(1));
        if (v.consec && v.exp_writes > 0)
            check("consecutive_writes", 128'(last_wcyc - first_wcyc), 128'(v.exp_writes - 1));
        $display("row %0d: sel4=%0d res=%0dx%0d beats=%0d writes=%0d error=%0d",
                 row, v.sel4, v.x, v.y, v.nbeats, n_writes, error_s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        vec_t rv;
        //          sel4 x  y  mask     beats last mode wr err consec
        vecs[0] = '{1'b0, 4, 2, 4'hF,    8, 1'b1, 0, 8, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 4, 2, 4'hF,    8, 1'b1, 1, 8, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4, 2, 4'hF,    5, 1'b1, 0, 5, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 4, 2, 4'hF,   11, 1'b1, 0, 8, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8, 2, 4'b0111, 4, 1'b1, 0, 4, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 0, 2, 4'hF,    2, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 3, 3, 4'h5,    9, 1'b1, 2, 9, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8, 2, 4'b1010, 6, 1'b1, 1, 4, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1, 1, 4'hF,    1, 1'b1, 0, 1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1, 1, 4'hF,    3, 1'b1, 1, 1, 1'b1, 1'b0};

        reset = 1'b1;
        sel4 = 1'b0;
        conf_x = '0; conf_y = '0; conf_mask = '0;
        apply = 1'b0; cmd_load = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        mem_wready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_applied1", 128'(applied1), 128'(1));
        check("reset_error1",   128'(error1),   128'(0));
        check("reset_wvalid1",  128'(wvalid1),  128'(0));
        check("reset_tready1",  128'(tready1),  128'(0));
        check("reset_applied4", 128'(applied4), 128'(1));
        check("reset_wvalid4",  128'(wvalid4),  128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int r = 0; r < 10; r++) begin
            run_row(r, vecs[r]);
        end

        // Apply without cmdLoad must leave the idle, errored state untouched.
        sel4 = 1'b0;
        apply = 1'b1;
        cmd_load = 1'b0;
        @(posedge clk);
        #1;
        apply = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("noload_applied", 128'(applied_s), 128'(1));
            check("noload_error",   128'(error_s),   128'(1));
            check("noload_tready",  128'(tready_s),  128'(0));
        end
        $display("apply without cmdLoad: applied=%0d error=%0d", applied_s, error_s);
        @(posedge clk);
        #1;

        // Reset after three beats of a load aborts it.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_mode = 0;
        conf_x = 11'd4; conf_y = 11'd2; conf_mask = 4'hF;
        exp_q.delete();
        n_writes = 0;
        @(posedge clk);
        #1;
        apply = 1'b1;
        cmd_load = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
        cmd_load = 1'b0;
        rv = '{1'b0, 4, 2, 4'hF, 3, 1'b0, 0, 3, 1'b0, 1'b0};
        send_beats(1, rv, ok);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_applied", 128'(applied_s), 128'(1));
        check("midreset_wvalid",  128'(wvalid_s),  128'(0));
        check("midreset_tready",  128'(tready_s),  128'(0));
        check("midreset_error",   128'(error_s),   128'(0));
        $display("reset mid-load: applied=%0d wvalid=%0d", applied_s, wvalid_s);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        run_row(0, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
